// File: rtl/counter_control_if.sv
// counter_control_if: run-control handshake and datapath status/strobes for counter_control.
interface counter_control_if #(parameter int PERIOD_W = 8);
    logic                start;
    logic                dir;
    logic [PERIOD_W-1:0] period;
    logic                pause;
    logic                abort;
    logic                z;
    logic                m;
    logic                op;
    logic                c_ld;
    logic                c_clr;
    logic                busy;
    logic                done;
    logic [15:0]         steps;
    modport master (output start, dir, period, pause, abort, z, m,
                    input op, c_ld, c_clr, busy, done, steps);
    modport slave  (input start, dir, period, pause, abort, z, m,
                    output op, c_ld, c_clr, busy, done, steps);
endinterface

// File: rtl/counter_control.sv
// counter_control: sequences clear/step strobes for an external up/down counter datapath.
module counter_control #(
    parameter int PERIOD_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    counter_control_if.slave ctl
);
    typedef enum logic [2:0] {IDLE, CLEAR, COUNT, PAUSED, DONE} state_e;
    state_e              state_q;
    logic [PERIOD_W-1:0] pc_q;
    logic [PERIOD_W-1:0] per_q;
    logic                dir_q;
    logic [15:0]         steps_q;
    logic                term;
    assign term      = dir_q ? ctl.z : ctl.m;
    // A step is withheld on the terminal value so the counter never overshoots.
    assign ctl.c_ld  = (state_q == COUNT) && !ctl.abort && !ctl.pause && !term && (pc_q == '0);
    assign ctl.c_clr = (state_q == CLEAR);
    assign ctl.busy  = (state_q == CLEAR) || (state_q == COUNT) || (state_q == PAUSED);
    assign ctl.done  = (state_q == DONE);
    assign ctl.op    = dir_q;
    assign ctl.steps = steps_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= '0;
            per_q   <= '0;
            dir_q   <= 1'b0;
            steps_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (ctl.start) begin
                    dir_q   <= ctl.dir;
                    per_q   <= ctl.period;
                    pc_q    <= ctl.period;
                    steps_q <= '0;
                    state_q <= ctl.dir ? COUNT : CLEAR;
                end
                CLEAR: begin
                    pc_q    <= per_q;
                    state_q <= ctl.abort ? IDLE : COUNT;
                end
                COUNT: begin
                    if (ctl.abort) state_q <= IDLE;
                    else if (ctl.pause) state_q <= PAUSED;
                    else if (term) state_q <= DONE;
                    else if (pc_q == '0) begin
                        pc_q    <= per_q;
                        steps_q <= steps_q + {15'd0, steps_q != 16'hFFFF};
                    end else pc_q <= pc_q - 1'b1;
                end
                PAUSED: begin
                    if (ctl.abort) state_q <= IDLE;
                    else if (!ctl.pause) state_q <= COUNT;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_control.sv
// tb_counter_control: directed runs against a bench-side counter model with a scoreboard of expected run outcomes.
module tb_counter_control;
    typedef struct {
        string       tag;
        logic [31:0] mask;
        int          done_off;
        int          steps;
        logic [15:0] c;
        int          clr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    counter_control_if #(.PERIOD_W(8)) ctl ();
    counter_control #(.PERIOD_W(8)) dut (.clk_i(clk), .rst_ni(rst_n), .ctl(ctl));
    always #5 clk = ~clk;

    // Counter datapath model; frc lets the bench preset the value.
    logic        frc;
    logic [15:0] frc_val;
    logic [15:0] c_val;
    always @(posedge clk) begin
        if (frc) c_val <= frc_val;
        else if (ctl.c_clr) c_val <= 16'h0000;
        else if (ctl.c_ld) c_val <= ctl.op ? c_val - 16'd1 : c_val + 16'd1;
    end
    assign ctl.z = (c_val == 16'h0000);
    assign ctl.m = (c_val == 16'hFFFF);

    // Run monitor: offsets are negedge counts since the accepted start.
    int          cyc = 0;
    int          start_cyc = 0;
    logic [31:0] ld_mask = '0;
    int          ld_cnt = 0;
    int          clr_cnt = 0;
    int          done_off = -1;
    int          bad = 0;
    logic        run_dir = 1'b0;
    always @(negedge clk) begin
        int off;
        off = cyc - start_cyc;
        cyc <= cyc + 1;
        if (rst_n && ctl.start && !ctl.busy && !ctl.done) begin
            start_cyc <= cyc;
            ld_mask   <= '0;
            ld_cnt    <= 0;
            clr_cnt   <= 0;
            done_off  <= -1;
            bad       <= 0;
            run_dir   <= ctl.dir;
        end else begin
            if (ctl.c_ld) begin
                ld_cnt <= ld_cnt + 1;
                if (off < 32) ld_mask[off] <= 1'b1;
            end
            if (ctl.c_clr) clr_cnt <= clr_cnt + 1;
            if (ctl.done) done_off <= off;
            if ((ctl.c_ld && ctl.c_clr) || ((ctl.busy || ctl.done) && ctl.op !== run_dir)) bad <= bad + 1;
        end
    end

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preset(input logic [15:0] v);
        frc = 1'b1;
        frc_val = v;
        step(1);
        frc = 1'b0;
    endtask

    task automatic start_run(input string tag, input logic d, input logic [7:0] p, input logic [31:0] mask,
                             input int doff, input int st, input logic [15:0] c, input int clr);
        exp_t e;
        e.tag = tag; e.mask = mask; e.done_off = doff; e.steps = st; e.c = c; e.clr = clr;
        sb.push_back(e);
        ctl.start = 1'b1;
        ctl.dir = d;
        ctl.period = p;
        step(1);
        ctl.start = 1'b0;
    endtask

    task automatic finish_run();
        exp_t e;
        int   i;
        i = 0;
        while (i < 200 && (ctl.busy || ctl.done)) begin
            step(1);
            i++;
        end
        step(2);
        e = sb.pop_front();
        chk({e.tag, "_timeout"}, 32'(ctl.busy), 32'd0);
        chk({e.tag, "_ld_cycles"}, ld_mask, e.mask);
        chk({e.tag, "_done_at"}, done_off, e.done_off);
        chk({e.tag, "_ld_count"}, ld_cnt, e.steps);
        chk({e.tag, "_steps"}, 32'(ctl.steps), e.steps);
        chk({e.tag, "_c"}, 32'(c_val), 32'(e.c));
        chk({e.tag, "_clr_count"}, clr_cnt, e.clr);
        chk({e.tag, "_op_strobe"}, bad, 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_op"}, 32'(ctl.op), 32'd0);
        chk({tag, "_c_ld"}, 32'(ctl.c_ld), 32'd0);
        chk({tag, "_c_clr"}, 32'(ctl.c_clr), 32'd0);
        chk({tag, "_busy"}, 32'(ctl.busy), 32'd0);
        chk({tag, "_done"}, 32'(ctl.done), 32'd0);
        chk({tag, "_steps"}, 32'(ctl.steps), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        ctl.start = 1'b0; ctl.dir = 1'b0; ctl.period = '0; ctl.pause = 1'b0; ctl.abort = 1'b0;
        frc = 1'b1; frc_val = 16'h0000;
        step(3);
        chk_quiet("reset");
        rst_n = 1'b1;
        frc = 1'b0;
        step(1);
        chk_quiet("post_reset");

        // Down from 3, one step per cycle.
        preset(16'd3);
        start_run("down3", 1'b1, 8'd0, 32'h0000_000E, 5, 3, 16'h0000, 0);
        chk("down3_busy", 32'(ctl.busy), 32'd1);
        chk("down3_no_clear", 32'(ctl.c_clr), 32'd0);
        chk("down3_first_ld", 32'(ctl.c_ld), 32'd1);
        finish_run();

        // Up run: clear, then the bench presets FFFD on the clear edge.
        preset(16'd9);
        start_run("up_fffd", 1'b0, 8'd0, 32'h0000_000C, 5, 2, 16'hFFFF, 1);
        chk("up_clear_strobe", 32'(ctl.c_clr), 32'd1);
        frc = 1'b1; frc_val = 16'hFFFD;
        step(1);
        frc = 1'b0;
        finish_run();

        // Down from 2 with period 2.
        preset(16'd2);
        start_run("down2_p2", 1'b1, 8'd2, 32'h0000_0048, 8, 2, 16'h0000, 0);
        finish_run();

        // Down from 5, period 1, paused four cycles after the first step.
        preset(16'd5);
        start_run("pause", 1'b1, 8'd1, 32'h0000_AA04, 17, 5, 16'h0000, 0);
        step(2);
        ctl.pause = 1'b1;
        step(2);
        chk("pause_busy", 32'(ctl.busy), 32'd1);
        chk("pause_no_ld", 32'(ctl.c_ld), 32'd0);
        step(2);
        ctl.pause = 1'b0;
        finish_run();

        // Down from 10, abort after two steps; a start while busy is ignored.
        preset(16'd10);
        start_run("abort", 1'b1, 8'd0, 32'h0000_0006, -1, 2, 16'd8, 0);
        step(1);
        ctl.start = 1'b1; ctl.dir = 1'b0; ctl.period = 8'd5;
        step(1);
        ctl.start = 1'b0;
        ctl.abort = 1'b1;
        step(1);
        ctl.abort = 1'b0;
        finish_run();

        // Abort while clearing still clears but never completes.
        preset(16'd7);
        start_run("abort_clear", 1'b0, 8'd0, 32'h0, -1, 0, 16'h0000, 1);
        ctl.abort = 1'b1;
        step(1);
        ctl.abort = 1'b0;
        finish_run();

        // Asynchronous reset in the middle of a down run.
        preset(16'd10);
        ctl.start = 1'b1; ctl.dir = 1'b1; ctl.period = 8'd3;
        step(1);
        ctl.start = 1'b0;
        step(6);
        chk("mid_run_busy", 32'(ctl.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_quiet("async_reset");
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("no_restart_busy", 32'(ctl.busy), 32'd0);
        chk("no_restart_c", 32'(c_val), 32'(16'd10 - 16'd1));

        // Down start with z already set completes without a step.
        preset(16'd0);
        start_run("zero_down", 1'b1, 8'd5, 32'h0, 2, 0, 16'h0000, 0);
        finish_run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/counter_control.md
COUNTER_CONTROL -- requirements
Module: counter_control

Interface
REQ-001 Parameter PERIOD_W, default 8, width of the step-period input and prescaler.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; one clock, no other clock domains.
REQ-004 start  input  1  request a count run; sampled only in IDLE.
REQ-005 dir  input  1  0 = count up to maximum, 1 = count down to zero; sampled with start.
REQ-006 period  input  PERIOD_W  step interval: one step every period+1 COUNT cycles; sampled with start.
REQ-007 pause  input  1  level; freezes the run while high.
REQ-008 abort  input  1  level; terminates the run.
REQ-009 z  input  1  datapath status: counter value == 16'h0000.
REQ-010 m  input  1  datapath status: counter value == 16'hFFFF.
REQ-011 op  output  1  datapath operation: 0 = add 1, 1 = subtract 1.
REQ-012 c_ld  output  1  datapath load strobe (register takes C op 1).
REQ-013 c_clr  output  1  datapath clear strobe (register takes 0).
REQ-014 busy  output  1  high in CLEAR, COUNT, PAUSED.
REQ-015 done  output  1  one-cycle pulse on normal completion.
REQ-016 steps  output  16  number of c_ld pulses issued in the current/last run.

Function
REQ-017 States: IDLE, CLEAR, COUNT, PAUSED, DONE; registered state, one-hot or binary.
REQ-018 IDLE: start=1 latches dir into dir_r, period into per_r, and clears steps; next state CLEAR if dir=0, COUNT if dir=1.
REQ-019 CLEAR: c_clr=1 for exactly one cycle; next state COUNT.
REQ-020 On every entry to COUNT from CLEAR or IDLE, prescaler pc loads per_r.
REQ-021 Terminal condition term = m when dir_r=0, z when dir_r=1.
REQ-022 COUNT, priority order: abort -> IDLE; pause -> PAUSED; term -> DONE; pc==0 -> c_ld=1, pc reloads per_r, steps increments; else pc decrements.
REQ-023 c_ld is combinational from state, pc, term, pause, abort; never asserted when term=1, so no step past the terminal value.
REQ-024 op = dir_r in all states; c_ld and c_clr never asserted in the same cycle.
REQ-025 PAUSED: pc, steps, dir_r held; no strobes; abort -> IDLE; pause low -> COUNT without reloading pc.
REQ-026 DONE: done=1 for one cycle; next state IDLE unconditionally.
REQ-027 abort in CLEAR -> IDLE; c_clr still issued that cycle; no done pulse.
REQ-028 start while not IDLE ignored; changes to dir/period mid-run have no effect.
REQ-029 Down run with z already 1 at COUNT entry: DONE on first COUNT cycle, steps=0, no c_ld.
REQ-030 steps saturates at 16'hFFFF; holds value after run ends until next accepted start.

Reset
REQ-031 reset low asynchronously forces state IDLE, pc=0, dir_r=0, per_r=0, steps=0.
REQ-032 During and immediately after reset: op=0, c_ld=0, c_clr=0, busy=0, done=0.
REQ-033 reset mid-run aborts with no done pulse; first run after release requires a fresh start.

Verification
REQ-034 Down, C=3, period=0: start -> COUNT next cycle, c_ld on 3 consecutive cycles (C 3,2,1,0), DONE on 4th, done pulse, steps=3, busy falls with DONE.
REQ-035 Up, C=16'hFFFD, period=0: CLEAR one cycle (c_clr=1, C=0); bench forces C=16'hFFFD after clear -> 2 c_ld, m=1, done, steps=2, op=0 throughout.
REQ-036 Down, C=2, period=2: c_ld on COUNT cycles 3 and 6, done on cycle 7, steps=2.
REQ-037 Down, C=5, period=1, pause high 4 cycles after first c_ld: no c_ld while paused, spacing resumes from held pc; total steps=5.
REQ-038 Down, C=10, abort after 2 steps: IDLE next cycle, no done, steps=2, C=8; start while busy ignored.
REQ-039 reset low mid-COUNT: all outputs 0 asynchronously; down start with z=1: done after one COUNT cycle, steps=0.
